kf8237_host_programmer: RTL

// CPU-side I/O initiator for the KF8237 DMA controller: turns one channel command into the 8237 register access sequence.

---
 rtl/kf8237_pkg.sv | 35 +++
 rtl/kf8237_io_cycle.sv | 158 +++++++++++++++
 rtl/kf8237_host_programmer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/kf8237_pkg.sv
// Shared constants and types for the KF8237 host-side programmer.
package kf8237_pkg;

    localparam logic [3:0] REG_CMD_STATUS   = 4'h8;
    localparam logic [3:0] REG_REQUEST      = 4'h9;
    localparam logic [3:0] REG_SINGLE_MASK  = 4'hA;
    localparam logic [3:0] REG_MODE         = 4'hB;
    localparam logic [3:0] REG_CLR_BYTE_PTR = 4'hC;
    localparam logic [3:0] REG_MASTER_CLR   = 4'hD;
    localparam logic [3:0] REG_CLR_MASK     = 4'hE;
    localparam logic [3:0] REG_ALL_MASK     = 4'hF;

    localparam int unsigned PHASE_CNT_W = 8;
    localparam int unsigned STEP_W      = 3;

    typedef enum logic {
        OP_PROGRAM  = 1'b0,
        OP_READBACK = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_GAP    = 3'd1,
        PH_SETUP  = 3'd2,
        PH_STROBE = 3'd3,
        PH_HOLD   = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_t;

endpackage

// File: rtl/kf8237_io_cycle.sv
// One 8237 register access: GAP -> SETUP -> STROBE -> HOLD, owning the CPU-port pins.
module kf8237_io_cycle
    import kf8237_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       more,
    input  logic       is_write,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    input  logic       dma_bus_busy,
    input  logic [7:0] data_in,
    output logic       done_c,
    output logic       error_c,
    output logic [7:0] rdata,
    output logic       chip_select_n,
    output logic       io_read_n,
    output logic       io_write_n,
    output logic [3:0] address_out,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    phase_t                 phase, phase_d;
    logic [PHASE_CNT_W-1:0] count, count_d;
    logic                   err_q;
    logic                   last_c;
    logic                   in_strobe_hold;
    int unsigned            phase_len;
    logic                   cs_n_d, rd_n_d, wr_n_d, en_d;
    logic [3:0]             addr_d;
    logic [7:0]             data_d;

    // Length of the current phase and whether this is its final cycle
    always_comb begin
        phase_len = 1;
        case (phase)
            PH_SETUP:  phase_len = SETUP_CYCLES;
            PH_STROBE: phase_len = STROBE_CYCLES;
            PH_HOLD:   phase_len = HOLD_CYCLES;
            default:   phase_len = 1;
        endcase
        last_c         = (count == PHASE_CNT_W'(phase_len - 1));
        in_strobe_hold = (phase == PH_STROBE) || (phase == PH_HOLD);
        error_c        = err_q || (in_strobe_hold && dma_bus_busy);
    end

    // Phase register, per-access error flag and read-data capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= PH_IDLE;
            count <= '0;
            err_q <= 1'b0;
            rdata <= '0;
        end else begin
            phase <= phase_d;
            count <= count_d;
            if (phase == PH_GAP) begin
                err_q <= 1'b0;
            end else if (in_strobe_hold && dma_bus_busy) begin
                err_q <= 1'b1;
            end
            if (phase == PH_STROBE && last_c) begin
                rdata <= data_in;
            end
        end
    end

    // Next phase; GAP waits out bus ownership, a started access always runs to the end
    always_comb begin
        phase_d = phase;
        count_d = count;
        done_c  = 1'b0;
        case (phase)
            PH_IDLE: begin
                if (start) begin
                    phase_d = PH_GAP;
                end
            end
            PH_GAP: begin
                if (!dma_bus_busy) begin
                    phase_d = PH_SETUP;
                    count_d = '0;
                end
            end
            PH_SETUP: begin
                if (last_c) begin
                    phase_d = PH_STROBE;
                    count_d = '0;
                end else begin
                    count_d = count + PHASE_CNT_W'(1);
                end
            end
            PH_STROBE: begin
                if (last_c) begin
                    phase_d = PH_HOLD;
                    count_d = '0;
                end else begin
                    count_d = count + PHASE_CNT_W'(1);
                end
            end
            PH_HOLD: begin
                if (last_c) begin
                    done_c  = 1'b1;
                    phase_d = more ? PH_GAP : PH_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count + PHASE_CNT_W'(1);
                end
            end
            default: begin
                phase_d = PH_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Pin values for the coming phase; address/data latched on entry to SETUP
    always_comb begin
        cs_n_d = !((phase_d == PH_SETUP) || (phase_d == PH_STROBE) || (phase_d == PH_HOLD));
        rd_n_d = !((phase_d == PH_STROBE) && !is_write);
        wr_n_d = !((phase_d == PH_STROBE) && is_write);
        en_d   = !cs_n_d && is_write;
        addr_d = address_out;
        data_d = data_out;
        if (phase == PH_GAP && phase_d == PH_SETUP) begin
            addr_d = addr;
            if (is_write) begin
                data_d = wdata;
            end
        end
    end

    // Registered bus pins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chip_select_n <= 1'b1;
            io_read_n     <= 1'b1;
            io_write_n    <= 1'b1;
            address_out   <= '0;
            data_out      <= '0;
            data_out_en   <= 1'b0;
        end else begin
            chip_select_n <= cs_n_d;
            io_read_n     <= rd_n_d;
            io_write_n    <= wr_n_d;
            address_out   <= addr_d;
            data_out      <= data_d;
            data_out_en   <= en_d;
        end
    end

endmodule

// File: rtl/kf8237_host_programmer.sv
// Turns one channel command into the 8237 register access sequence and reports completion.
module kf8237_host_programmer
    import kf8237_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_channel,
    input  logic [5:0]  cmd_mode,
    input  logic        cmd_unmask,
    input  logic [15:0] cmd_address,
    input  logic [15:0] cmd_count,
    input  logic        dma_bus_busy,
    output logic        chip_select_n,
    output logic        io_read_n,
    output logic        io_write_n,
    output logic [3:0]  address_out,
    output logic [7:0]  data_out,
    output logic        data_out_en,
    input  logic [7:0]  data_in,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [15:0] rsp_address,
    output logic [15:0] rsp_count
);

    seq_t              state, state_d;
    logic [STEP_W-1:0] step, last_step;
    op_t               op_q;
    logic [1:0]        ch_q;
    logic [5:0]        mode_q;
    logic              unmask_q;
    logic [15:0]       addr_q, cnt_q;
    logic              sticky_err;
    logic [7:0]        rb_addr_lo, rb_addr_hi, rb_cnt_lo;
    logic              accept_c, more_c;
    logic              acc_write;
    logic [3:0]        acc_addr;
    logic [7:0]        acc_data;
    logic              io_done_c, io_error_c;
    logic [7:0]        io_rdata;
    logic              ready_d, valid_d, error_d;
    logic [15:0]       rsp_addr_d, rsp_cnt_d;

    assign accept_c  = (state == SEQ_IDLE) && cmd_valid;
    assign last_step = (op_q == OP_READBACK) ? STEP_W'(4) : (unmask_q ? STEP_W'(7) : STEP_W'(6));
    assign more_c    = (step != last_step);

    kf8237_io_cycle #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_io (
        .clock         (clock),
        .reset         (reset),
        .start         (accept_c),
        .more          (more_c),
        .is_write      (acc_write),
        .addr          (acc_addr),
        .wdata         (acc_data),
        .dma_bus_busy  (dma_bus_busy),
        .data_in       (data_in),
        .done_c        (io_done_c),
        .error_c       (io_error_c),
        .rdata         (io_rdata),
        .chip_select_n (chip_select_n),
        .io_read_n     (io_read_n),
        .io_write_n    (io_write_n),
        .address_out   (address_out),
        .data_out      (data_out),
        .data_out_en   (data_out_en)
    );

    // Step-decode ROM: register address, data and direction for the current step
    always_comb begin
        acc_write = 1'b1;
        acc_addr  = REG_CLR_BYTE_PTR;
        acc_data  = 8'h00;
        if (op_q == OP_PROGRAM) begin
            case (step)
                3'd0: begin acc_addr = REG_SINGLE_MASK;      acc_data = {5'b0, 1'b1, ch_q}; end
                3'd1: begin acc_addr = REG_CLR_BYTE_PTR;     acc_data = 8'h00;              end
                3'd2: begin acc_addr = {1'b0, ch_q, 1'b0};   acc_data = addr_q[7:0];        end
                3'd3: begin acc_addr = {1'b0, ch_q, 1'b0};   acc_data = addr_q[15:8];       end
                3'd4: begin acc_addr = {1'b0, ch_q, 1'b1};   acc_data = cnt_q[7:0];         end
                3'd5: begin acc_addr = {1'b0, ch_q, 1'b1};   acc_data = cnt_q[15:8];        end
                3'd6: begin acc_addr = REG_MODE;             acc_data = {mode_q, ch_q};     end
                default: begin acc_addr = REG_SINGLE_MASK;   acc_data = {5'b0, 1'b0, ch_q}; end
            endcase
        end else begin
            case (step)
                3'd0:       begin acc_write = 1'b1; acc_addr = REG_CLR_BYTE_PTR;   end
                3'd1, 3'd2: begin acc_write = 1'b0; acc_addr = {1'b0, ch_q, 1'b0}; end
                default:    begin acc_write = 1'b0; acc_addr = {1'b0, ch_q, 1'b1}; end
            endcase
        end
    end

    // Sequencer state, step counter, latched command and read-back bytes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= SEQ_IDLE;
            step       <= '0;
            op_q       <= OP_PROGRAM;
            ch_q       <= '0;
            mode_q     <= '0;
            unmask_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            sticky_err <= 1'b0;
            rb_addr_lo <= '0;
            rb_addr_hi <= '0;
            rb_cnt_lo  <= '0;
        end else begin
            state <= state_d;
            if (accept_c) begin
                step       <= '0;
                op_q       <= op_t'(cmd_op);
                ch_q       <= cmd_channel;
                mode_q     <= cmd_mode;
                unmask_q   <= cmd_unmask;
                addr_q     <= cmd_address;
                cnt_q      <= cmd_count;
                sticky_err <= 1'b0;
            end else if (io_done_c) begin
                step <= step + STEP_W'(1);
                if (io_error_c) begin
                    sticky_err <= 1'b1;
                end
                if (op_q == OP_READBACK) begin
                    case (step)
                        3'd1:    rb_addr_lo <= io_rdata;
                        3'd2:    rb_addr_hi <= io_rdata;
                        3'd3:    rb_cnt_lo  <= io_rdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Next sequencer state
    always_comb begin
        state_d = state;
        case (state)
            SEQ_IDLE: if (cmd_valid) state_d = SEQ_RUN;
            SEQ_RUN:  if (io_done_c && !more_c) state_d = SEQ_DONE;
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
    end

    // Response values for the coming cycle
    always_comb begin
        ready_d    = (state_d == SEQ_IDLE);
        valid_d    = (state_d == SEQ_DONE);
        error_d    = (state_d == SEQ_DONE) && (sticky_err || io_error_c);
        rsp_addr_d = rsp_address;
        rsp_cnt_d  = rsp_count;
        if (state == SEQ_RUN && state_d == SEQ_DONE && op_q == OP_READBACK) begin
            rsp_addr_d = {rb_addr_hi, rb_addr_lo};
            rsp_cnt_d  = {io_rdata, rb_cnt_lo};
        end
    end

    // Registered response and handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_address <= '0;
            rsp_count   <= '0;
        end else begin
            cmd_ready   <= ready_d;
            rsp_valid   <= valid_d;
            rsp_error   <= error_d;
            rsp_address <= rsp_addr_d;
            rsp_count   <= rsp_cnt_d;
        end
    end

endmodule
